// File: rtl/ex_wb_buffer.sv
// ex_wb_buffer: EX-to-WB result FIFO with per-lane FP32 [0.0, 1.0] saturation
// applied at enqueue, draining one entry per cycle into the banked RF port.
module ex_wb_buffer #(
    parameter int DataWidth    = 32,
    parameter int TotalNumBank = 8,
    parameter int AddrWidth    = 5,
    parameter int DEPTH        = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      sclr,
    input  logic                      res_valid_e,
    output logic                      res_ready_e,
    input  logic [TotalNumBank-1:0]   writeEn_e,
    input  logic [AddrWidth-1:0]      writeAddr_e,
    input  logic [3:0]                des_mask_e,
    input  logic                      des_sat_e,
    input  logic [4*DataWidth-1:0]    result_e,
    input  logic                      rf_busy,
    output logic [TotalNumBank-1:0]   writeEn_w,
    output logic [AddrWidth-1:0]      writeAddr_w,
    output logic [3:0]                writeMask_w,
    output logic [4*DataWidth-1:0]    writeData_w,
    output logic [$clog2(DEPTH):0]    wb_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = 4 * DataWidth;

    logic [TotalNumBank-1:0] en_q   [DEPTH];
    logic [AddrWidth-1:0]    addr_q [DEPTH];
    logic [3:0]              mask_q [DEPTH];
    logic [LW-1:0]           data_q [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          empty;
    logic [LW-1:0] sat_data;

    // Negative values and NaNs collapse to 0.0; anything at or above 1.0 clamps.
    function automatic logic [DataWidth-1:0] sat32(input logic [DataWidth-1:0] x);
        if (x[31])
            sat32 = '0;
        else if ((&x[30:23]) && (|x[22:0]))
            sat32 = '0;
        else if (x[30:0] >= 31'h3F800000)
            sat32 = DataWidth'(32'h3F800000);
        else
            sat32 = x;
    endfunction

    always_comb begin
        sat_data = result_e;
        if (des_sat_e) begin
            for (int i = 0; i < 4; i++)
                sat_data[i*DataWidth +: DataWidth] =
                    sat32(result_e[i*DataWidth +: DataWidth]);
        end
    end

    assign empty       = (count == '0);
    assign res_ready_e = (count != CW'(DEPTH));
    assign pop         = ~empty & ~rf_busy;
    // Beats with no bank or no lane selected complete the handshake but vanish.
    assign push        = res_valid_e & res_ready_e
                       & (|writeEn_e) & (|des_mask_e);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (sclr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !sclr) begin
            en_q[wr_ptr]   <= writeEn_e;
            addr_q[wr_ptr] <= writeAddr_e;
            mask_q[wr_ptr] <= des_mask_e;
            data_q[wr_ptr] <= sat_data;
        end
    end

    assign writeEn_w   = pop   ? en_q[rd_ptr]   : '0;
    assign writeMask_w = pop   ? mask_q[rd_ptr] : '0;
    assign writeAddr_w = empty ? '0 : addr_q[rd_ptr];
    assign writeData_w = empty ? '0 : data_q[rd_ptr];
    assign wb_count    = count;

endmodule

// File: tb/tb_ex_wb_buffer.sv
// Bench for ex_wb_buffer: vector table plus directed corner sequences,
// with a write-order scoreboard fed at handshake and drained by a monitor.
module tb_ex_wb_buffer;

    localparam int DW = 32;
    localparam int NB = 8;
    localparam int AW = 5;
    localparam int D  = 4;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           sclr = 1'b0;
    logic           res_valid_e = 1'b0;
    logic           res_ready_e;
    logic [NB-1:0]  writeEn_e = '0;
    logic [AW-1:0]  writeAddr_e = '0;
    logic [3:0]     des_mask_e = '0;
    logic           des_sat_e = 1'b0;
    logic [4*DW-1:0] result_e = '0;
    logic           rf_busy = 1'b0;
    logic [NB-1:0]  writeEn_w;
    logic [AW-1:0]  writeAddr_w;
    logic [3:0]     writeMask_w;
    logic [4*DW-1:0] writeData_w;
    logic [2:0]     wb_count;

    ex_wb_buffer #(
        .DataWidth(DW), .TotalNumBank(NB), .AddrWidth(AW), .DEPTH(D)
    ) dut (
        .clk(clk), .rstn(rstn), .sclr(sclr),
        .res_valid_e(res_valid_e), .res_ready_e(res_ready_e),
        .writeEn_e(writeEn_e), .writeAddr_e(writeAddr_e),
        .des_mask_e(des_mask_e), .des_sat_e(des_sat_e),
        .result_e(result_e), .rf_busy(rf_busy),
        .writeEn_w(writeEn_w), .writeAddr_w(writeAddr_w),
        .writeMask_w(writeMask_w), .writeData_w(writeData_w),
        .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   en;
        logic [4:0]   addr;
        logic [3:0]   mask;
        logic         sat;
        logic [127:0] data;
        logic [127:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0]   en;
        logic [4:0]   addr;
        logic [3:0]   mask;
        logic [127:0] data;
    } wr_t;

    wr_t  sb[$];
    vec_t tbl[8];
    int   errors = 0;
    int   checks = 0;
    logic acc;
    int   n_acc;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] sat_model(input logic [127:0] d,
                                               input logic s);
        logic [31:0] x;
        sat_model = d;
        if (s) begin
            for (int i = 0; i < 4; i++) begin
                x = d[i*32 +: 32];
                if (x[31] || x > 32'h7F800000)
                    x = 32'h0;
                else if (x >= 32'h3F800000)
                    x = 32'h3F800000;
                sat_model[i*32 +: 32] = x;
            end
        end
    endfunction

    task automatic send(input logic [7:0] en, input logic [4:0] a,
                        input logic [3:0] m, input logic s,
                        input logic [127:0] d, input logic [127:0] e,
                        output logic ok);
        wr_t w;
        res_valid_e = 1'b1;
        writeEn_e   = en;
        writeAddr_e = a;
        des_mask_e  = m;
        des_sat_e   = s;
        result_e    = d;
        @(negedge clk);
        ok = res_ready_e;
        if (ok && en != 0 && m != 0 && !sclr) begin
            w.en = en; w.addr = a; w.mask = m; w.data = e;
            sb.push_back(w);
        end
        @(posedge clk);
        #1;
        res_valid_e = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((sb.size() != 0 || wb_count != 0) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_drained"}, 128'(sb.size() == 0 && wb_count == 0), 128'd1);
    endtask

    // Monitor: every RF write must match the oldest outstanding beat.
    always @(negedge clk) begin
        wr_t e;
        if (rstn) begin
            if (writeEn_w != 0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", 128'(writeEn_w), 128'd0);
                end else begin
                    e = sb.pop_front();
                    chk("wr_en",   128'(writeEn_w),   128'(e.en));
                    chk("wr_addr", 128'(writeAddr_w), 128'(e.addr));
                    chk("wr_mask", 128'(writeMask_w), 128'(e.mask));
                    chk("wr_data", writeData_w,       e.data);
                end
            end else begin
                chk("idle_mask", 128'(writeMask_w), 128'd0);
                if (wb_count == 0) begin
                    chk("empty_addr", 128'(writeAddr_w), 128'd0);
                    chk("empty_data", writeData_w, 128'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{8'h04, 5'd3, 4'hF, 1'b0, {4{32'h40000000}}, {4{32'h40000000}}};
        tbl[1] = '{8'h10, 5'd7, 4'hF, 1'b1,
                   {32'h3F000000, 32'h40490FDB, 32'h7FC00000, 32'hBF800000},
                   {32'h3F000000, 32'h3F800000, 32'h00000000, 32'h00000000}};
        tbl[2] = '{8'h81, 5'd31, 4'h5, 1'b1,
                   {32'h80000000, 32'h7F800000, 32'h3F800000, 32'h3F7FFFFF},
                   {32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3F7FFFFF}};
        tbl[3] = '{8'h02, 5'd1, 4'hA, 1'b1,
                   {32'hFF800000, 32'h7F800001, 32'h00000001, 32'hFFC00000},
                   {32'h00000000, 32'h00000000, 32'h00000001, 32'h00000000}};
        tbl[4] = '{8'h40, 5'd9, 4'h1, 1'b0,
                   {32'hBF800000, 32'h7FC00000, 32'h7F800000, 32'h12345678},
                   {32'hBF800000, 32'h7FC00000, 32'h7F800000, 32'h12345678}};
        tbl[5] = '{8'h00, 5'd4, 4'hF, 1'b0, {4{32'hCAFEF00D}}, 128'd0};
        tbl[6] = '{8'h08, 5'd4, 4'h0, 1'b0, {4{32'hCAFEF00D}}, 128'd0};
        tbl[7] = '{8'hFF, 5'd0, 4'h8, 1'b1,
                   {32'h00000000, 32'h3F7FFFFF, 32'h3F800001, 32'h7F7FFFFF},
                   {32'h00000000, 32'h3F7FFFFF, 32'h3F800000, 32'h3F800000}};

        // Reset held with a valid beat on the input.
        res_valid_e = 1'b1;
        writeEn_e   = 8'hFF;
        des_mask_e  = 4'hF;
        result_e    = {4{32'hDEADBEEF}};
        #2;
        chk("rst_en",    128'(writeEn_w),   128'd0);
        chk("rst_addr",  128'(writeAddr_w), 128'd0);
        chk("rst_mask",  128'(writeMask_w), 128'd0);
        chk("rst_data",  writeData_w,       128'd0);
        chk("rst_count", 128'(wb_count),    128'd0);
        chk("rst_ready", 128'(res_ready_e), 128'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count_held", 128'(wb_count), 128'd0);
        rstn = 1'b1;
        res_valid_e = 1'b0;
        @(posedge clk);
        #1;

        // First beat: no bypass before the edge, written the cycle after.
        writeEn_e = 8'h04; writeAddr_e = 5'd3; des_mask_e = 4'hF;
        result_e = {4{32'h40000000}}; des_sat_e = 1'b0; res_valid_e = 1'b1;
        #2;
        chk("no_bypass", 128'(writeEn_w), 128'd0);
        send(8'h04, 5'd3, 4'hF, 1'b0, {4{32'h40000000}}, {4{32'h40000000}}, acc);
        chk("t1_acc",   128'(acc),         128'd1);
        chk("t1_en",    128'(writeEn_w),   128'h04);
        chk("t1_addr",  128'(writeAddr_w), 128'd3);
        chk("t1_data",  writeData_w,       {4{32'h40000000}});
        chk("t1_count", 128'(wb_count),    128'd1);
        drain("t1");

        for (int i = 0; i < 8; i++) begin
            send(tbl[i].en, tbl[i].addr, tbl[i].mask, tbl[i].sat,
                 tbl[i].data, tbl[i].exp, acc);
            chk("tbl_acc", 128'(acc), 128'd1);
            drain("tbl");
        end

        // Backpressure: fill under rf_busy, fifth beat refused.
        rf_busy = 1'b1;
        n_acc = 0;
        for (int k = 0; k < 5; k++) begin
            send(8'h01 << k, 5'(10 + k), 4'hF, 1'b0, {4{32'(32'h100 + k)}},
                 {4{32'(32'h100 + k)}}, acc);
            n_acc += int'(acc);
        end
        chk("bp_accepted", 128'(n_acc),       128'd4);
        chk("bp_5th",      128'(acc),         128'd0);
        chk("bp_count",    128'(wb_count),    128'd4);
        chk("bp_ready",    128'(res_ready_e), 128'd0);
        rf_busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_consec", 128'(writeEn_w != 0), 128'd1);
        end
        drain("bp");

        // Dropped beats complete the handshake without occupying an entry.
        rf_busy = 1'b1;
        send(8'h20, 5'd5, 4'h3, 1'b0, {4{32'h55}}, {4{32'h55}}, acc);
        send(8'h00, 5'd6, 4'hF, 1'b0, {4{32'h66}}, 128'd0, acc);
        chk("drop_en_acc",   128'(acc),      128'd1);
        chk("drop_en_count", 128'(wb_count), 128'd1);
        send(8'h20, 5'd7, 4'h0, 1'b0, {4{32'h77}}, 128'd0, acc);
        chk("drop_mask_acc",   128'(acc),      128'd1);
        chk("drop_mask_count", 128'(wb_count), 128'd1);
        rf_busy = 1'b0;
        drain("drop");

        // Steady push+pop at count 2 through several pointer wraps.
        rf_busy = 1'b1;
        for (int k = 0; k < 2; k++)
            send(8'h01, 5'(k), 4'hF, 1'b0, {4{32'(32'hA00 + k)}},
                 {4{32'(32'hA00 + k)}}, acc);
        rf_busy = 1'b0;
        for (int k = 2; k < 12; k++) begin
            send(8'h02, 5'(k), 4'hF, 1'b0, {4{32'(32'hA00 + k)}},
                 {4{32'(32'hA00 + k)}}, acc);
            chk("pp_count", 128'(wb_count), 128'd2);
        end
        drain("pp");

        // Synchronous flush with a beat offered in the same cycle.
        rf_busy = 1'b1;
        for (int k = 0; k < 3; k++)
            send(8'h04, 5'(k), 4'hF, 1'b0, {4{32'(32'hB00 + k)}},
                 {4{32'(32'hB00 + k)}}, acc);
        chk("fl_count_pre", 128'(wb_count), 128'd3);
        sclr = 1'b1;
        send(8'h04, 5'd9, 4'hF, 1'b0, {4{32'hBBB}}, {4{32'hBBB}}, acc);
        sclr = 1'b0;
        sb.delete();
        chk("fl_count", 128'(wb_count),    128'd0);
        chk("fl_en",    128'(writeEn_w),   128'd0);
        chk("fl_ready", 128'(res_ready_e), 128'd1);
        rf_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("fl_count_after", 128'(wb_count), 128'd0);

        // Asynchronous reset asserted mid-cycle clears immediately.
        rf_busy = 1'b1;
        for (int k = 0; k < 3; k++)
            send(8'h08, 5'(k), 4'hF, 1'b0, {4{32'(32'hC00 + k)}},
                 {4{32'(32'hC00 + k)}}, acc);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_count", 128'(wb_count),    128'd0);
        chk("ar_en",    128'(writeEn_w),   128'd0);
        chk("ar_addr",  128'(writeAddr_w), 128'd0);
        chk("ar_data",  writeData_w,       128'd0);
        chk("ar_ready", 128'(res_ready_e), 128'd1);
        sb.delete();
        rf_busy = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ar_count_after", 128'(wb_count), 128'd0);

        // Random traffic with random RF stalls.
        for (int k = 0; k < 40; k++) begin
            logic [127:0] d;
            logic         s;
            rf_busy = ($urandom_range(0, 2) == 0);
            d = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1)
                d[31:0] = 32'h3F800000 + 32'($urandom_range(0, 2)) - 32'd1;
            s = 1'($urandom_range(0, 1));
            send(8'($urandom_range(0, 255)), 5'($urandom_range(0, 31)),
                 4'($urandom_range(0, 15)), s, d, sat_model(d, s), acc);
        end
        rf_busy = 1'b0;
        drain("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
